// File: rtl/pwm_dac_multi.sv
// Multi-channel PWM output stage: double-buffered sample/top registers, edge or
// centre-aligned counting, complementary pins with rising-edge dead time.
//
// state    | meaning
// CNT_UP   | counter climbing from 0 towards top
// CNT_DOWN | centre mode only, counter falling from top-1 towards 1
module pwm_dac_multi #(
   parameter int               CHANNELS  = 2,
   parameter int               WIDTH     = 9,
   parameter int               DEAD_TIME = 2,
   parameter logic [WIDTH-1:0] RESET_TOP = {WIDTH{1'b1}}
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic [WIDTH-1:0]          i_top,
   input  logic                      i_top_valid,
   input  logic                      i_mode,
   input  logic [CHANNELS*WIDTH-1:0] i_sample,
   input  logic                      i_sample_valid,
   output logic                      o_sample_ready,
   output logic [CHANNELS-1:0]       o_pwm,
   output logic [CHANNELS-1:0]       o_pwm_n,
   output logic                      o_cycle_end,
   output logic                      o_underrun
);

   typedef enum logic {CNT_UP = 1'b0, CNT_DOWN = 1'b1} dir_t;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   dir_t                      dir;
   logic [WIDTH-1:0]          cnt;
   logic [WIDTH-1:0]          top_act;
   logic [WIDTH-1:0]          top_pend;
   logic                      top_pend_vld;
   logic                      mode_act;
   logic [CHANNELS*WIDTH-1:0] cmp_act;
   logic [CHANNELS*WIDTH-1:0] cmp_pend;
   logic                      pend_full;
   logic                      underrun;
   logic                      cycle_end;
   logic                      accept;

   // Last cycle of a period: top in edge mode, 1 on the way down in centre mode
   // (top=1 never turns round, so its last value is 1 on the way up).
   assign cycle_end = (top_act == '0)
                    | (!mode_act && (cnt == top_act))
                    | (mode_act && (cnt == ONE) && ((dir == CNT_DOWN) || (top_act == ONE)));

   assign accept = i_sample_valid && !pend_full;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt <= '0;
         dir <= CNT_UP;
      end else if (cycle_end) begin
         cnt <= '0;
         dir <= CNT_UP;
      end else if (!mode_act) begin
         cnt <= cnt + ONE;
      end else begin
         case (dir)
            CNT_UP: begin
               if (cnt == top_act) begin
                  dir <= CNT_DOWN;
                  cnt <= cnt - ONE;
               end else begin
                  cnt <= cnt + ONE;
               end
            end
            CNT_DOWN: cnt <= cnt - ONE;
            default:  dir <= CNT_UP;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         top_act      <= RESET_TOP;
         top_pend     <= RESET_TOP;
         top_pend_vld <= 1'b0;
         mode_act     <= 1'b0;
         cmp_act      <= '0;
         cmp_pend     <= '0;
         pend_full    <= 1'b0;
         underrun     <= 1'b0;
      end else begin
         underrun <= cycle_end && !pend_full;
         if (cycle_end) begin
            mode_act <= i_mode;
            if (top_pend_vld) top_act <= top_pend;
            if (pend_full)    cmp_act <= cmp_pend;
         end
         // A load in the period-end cycle lands in pending, never straight in active.
         if (i_top_valid) begin
            top_pend     <= i_top;
            top_pend_vld <= 1'b1;
         end else if (cycle_end) begin
            top_pend_vld <= 1'b0;
         end
         if (accept) begin
            cmp_pend  <= i_sample;
            pend_full <= 1'b1;
         end else if (cycle_end) begin
            pend_full <= 1'b0;
         end
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic             raw;
      logic [DEAD_TIME:0] hist_p;
      logic [DEAD_TIME:0] hist_n;

      assign raw = cnt < cmp_act[c*WIDTH +: WIDTH];

      // A pin goes high only once its raw level has held for DEAD_TIME+1 samples,
      // so the two histories can never both be all-ones.
      if (DEAD_TIME == 0) begin : g_nodt
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               hist_p <= '0;
               hist_n <= '0;
            end else begin
               hist_p <= raw;
               hist_n <= !raw;
            end
         end
      end else begin : g_dt
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               hist_p <= '0;
               hist_n <= '0;
            end else begin
               hist_p <= {hist_p[DEAD_TIME-1:0], raw};
               hist_n <= {hist_n[DEAD_TIME-1:0], !raw};
            end
         end
      end

      assign o_pwm[c]   = &hist_p;
      assign o_pwm_n[c] = &hist_n;
   end

   assign o_sample_ready = !pend_full;
   assign o_cycle_end    = cycle_end;
   assign o_underrun     = underrun;

endmodule

// File: tb/tb_pwm_dac_multi.sv
// Directed bench for pwm_dac_multi: two instances (no dead time / dead time 2)
// share one stimulus; per-window counts are compared with hand-derived values.
module tb_pwm_dac_multi;

   localparam int CH = 2;
   localparam int W  = 4;

   logic          clk;
   logic          rst_n;
   logic [W-1:0]  top;
   logic          top_valid;
   logic          mode;
   logic [CH*W-1:0] sample;
   logic          sample_valid;

   logic          rdy0, end0, und0;
   logic [CH-1:0] p0, pn0;
   logic          rdy2, end2, und2;
   logic [CH-1:0] p2, pn2;

   int checks   = 0;
   int failures = 0;

   int n_p0, n_p1, n_pn0, n_pn1;
   int d_p0, d_p1, d_pn0, d_pn1;
   int n_end, n_und, n_rdy, n_both, n_ncomp, max_run, cur_run;

   pwm_dac_multi #(.CHANNELS(CH), .WIDTH(W), .DEAD_TIME(0)) dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_top(top), .i_top_valid(top_valid),
      .i_mode(mode), .i_sample(sample), .i_sample_valid(sample_valid),
      .o_sample_ready(rdy0), .o_pwm(p0), .o_pwm_n(pn0),
      .o_cycle_end(end0), .o_underrun(und0));

   pwm_dac_multi #(.CHANNELS(CH), .WIDTH(W), .DEAD_TIME(2)) dut2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_top(top), .i_top_valid(top_valid),
      .i_mode(mode), .i_sample(sample), .i_sample_valid(sample_valid),
      .o_sample_ready(rdy2), .o_pwm(p2), .o_pwm_n(pn2),
      .o_cycle_end(end2), .o_underrun(und2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic wait_end();
      for (int i = 0; i < 64; i++) begin
         if (end0) break;
         @(negedge clk);
      end
      check("cycle_end_seen", int'(end0), 1);
   endtask

   task automatic settle();
      repeat (3) begin
         wait_end();
         step();
      end
   endtask

   task automatic measure(input int n);
      n_p0 = 0; n_p1 = 0; n_pn0 = 0; n_pn1 = 0;
      d_p0 = 0; d_p1 = 0; d_pn0 = 0; d_pn1 = 0;
      n_end = 0; n_und = 0; n_rdy = 0; n_both = 0; n_ncomp = 0;
      max_run = 0; cur_run = 0;
      for (int i = 0; i < n; i++) begin
         n_p0  += int'(p0[0]);  n_p1  += int'(p0[1]);
         n_pn0 += int'(pn0[0]); n_pn1 += int'(pn0[1]);
         d_p0  += int'(p2[0]);  d_p1  += int'(p2[1]);
         d_pn0 += int'(pn2[0]); d_pn1 += int'(pn2[1]);
         n_end += int'(end0);
         n_und += int'(und0);
         n_rdy += int'(rdy0);
         if (((p2 & pn2) != '0) || ((p0 & pn0) != '0)) n_both++;
         if (pn0 != ~p0) n_ncomp++;
         cur_run = p0[0] ? cur_run + 1 : 0;
         if (cur_run > max_run) max_run = cur_run;
         @(negedge clk);
      end
   endtask

   task automatic load_top(input logic [W-1:0] t);
      top       = t;
      top_valid = 1'b1;
      step();
      top_valid = 1'b0;
   endtask

   initial begin
      rst_n        = 1'b0;
      top          = '0;
      top_valid    = 1'b0;
      mode         = 1'b0;
      sample       = '0;
      sample_valid = 1'b0;

      // reset state
      step();
      check("rst_pwm",       int'(p0),   0);
      check("rst_pwm_n",     int'(pn0),  0);
      check("rst_ready",     int'(rdy0), 1);
      check("rst_cycle_end", int'(end0), 0);
      check("rst_underrun",  int'(und0), 0);

      // edge mode, top 7, ch0=3 ch1=0, valid held
      rst_n        = 1'b1;
      sample       = {4'd0, 4'd3};
      sample_valid = 1'b1;
      load_top(4'd7);
      check("ready_drop", int'(rdy0), 0);
      settle();
      measure(16);
      check("edge_ch0_high",  n_p0,    6);
      check("edge_ch1_high",  n_p1,    0);
      check("edge_ch0_n",     n_pn0,   10);
      check("edge_compl",     n_ncomp, 0);
      check("edge_cycle_end", n_end,   2);
      check("edge_accepts",   n_rdy,   2);
      check("edge_underrun",  n_und,   0);
      check("edge_dt_both",   n_both,  0);

      // dead time: ch0=4, ch1=1
      sample = {4'd1, 4'd4};
      settle();
      measure(16);
      check("dt0_ch0_high", n_p0,  8);
      check("dt_ch0_p",     d_p0,  4);
      check("dt_ch0_n",     d_pn0, 4);
      check("dt_ch1_p",     d_p1,  0);
      check("dt_ch1_n",     d_pn1, 10);
      check("dt_both",      n_both, 0);

      // compare above top, compare zero
      sample = {4'd0, 4'd8};
      settle();
      measure(16);
      check("cmp_gt_top_ch0", n_p0,  16);
      check("cmp_gt_top_n0",  d_pn0, 0);
      check("cmp_zero_ch1",   n_p1,  0);
      check("cmp_zero_n1",    n_pn1, 16);

      // top = 0
      load_top(4'd0);
      settle();
      measure(8);
      check("top0_cycle_end", n_end, 8);
      check("top0_ch0_high",  n_p0,  8);

      // centre mode, top 7, ch0=3
      mode   = 1'b1;
      sample = {4'd0, 4'd3};
      load_top(4'd7);
      settle();
      measure(28);
      check("ctr_cycle_end", n_end,   2);
      check("ctr_ch0_high",  n_p0,    10);
      check("ctr_ch0_run",   max_run, 5);
      check("ctr_both",      n_both,  0);

      // sample offered in the period-end cycle, then starvation
      mode   = 1'b0;
      sample = {4'd0, 4'd2};
      settle();
      sample_valid = 1'b0;
      wait_end();
      check("pe_ready", int'(rdy0), 1);
      sample       = {4'd0, 4'd5};
      sample_valid = 1'b1;
      step();
      sample_valid = 1'b0;
      measure(8);
      check("pe_underrun", n_und, 1);
      check("pe_old_duty", n_p0,  2);
      check("pe_ready_lo", n_rdy, 0);
      check("pe_ready_up", int'(rdy0), 1);
      measure(8);
      check("pe_new_duty", n_p0,  5);
      check("pe_no_under", n_und, 0);
      measure(8);
      check("ur_kept_duty", n_p0,  5);
      check("ur_underrun",  n_und, 1);

      // async reset mid-period with pending buffer full
      sample       = {4'd0, 4'd6};
      sample_valid = 1'b1;
      step();
      sample_valid = 1'b0;
      check("ar_full", int'(rdy0), 0);
      step();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_pwm",       int'(p0),   0);
      check("ar_pwm_n",     int'(pn0),  0);
      check("ar_ready",     int'(rdy0), 1);
      check("ar_cycle_end", int'(end0), 0);
      check("ar_underrun",  int'(und0), 0);
      check("ar_dt_pins",   int'({p2, pn2}), 0);
      step();
      rst_n = 1'b1;
      measure(16);
      check("ar_reset_top",  n_end, 1);
      check("ar_cmp_zero",   n_p0,  0);
      check("ar_pwm_n_rise", n_pn0, 15);
      check("ar_underrun2",  int'(und0), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pwm_dac_multi.md
# pwm_dac_multi

Parametrised multi-channel PWM output stage for the audio path. It takes parallel sample words from the audio processing unit through a valid/ready handshake and double-buffers them so that compare values change only at period boundaries. It drives one true and one complementary pin per channel, with programmable dead time, in either edge-aligned or centre-aligned counting mode. It supersedes the single-channel `pwm` instance used between the APU and the PMOD pins.

## Interface

**Parameters**
- `CHANNELS`, default 2: number of PWM channels.
- `WIDTH`, default 9: counter, top and compare width in bits.
- `DEAD_TIME`, default 2: clocks both pins of a channel are held low around each transition; 0 disables dead time.
- `RESET_TOP`, default `{WIDTH{1'b1}}`: active top value after reset.

**Ports** (name, direction, width, meaning)
- `i_clk`, in, 1: sole clock.
- `i_rst_n`, in, 1: asynchronous active-low reset.
- `i_top`, in, WIDTH: period top value.
- `i_top_valid`, in, 1: loads `i_top` into the pending top register (always accepted).
- `i_mode`, in, 1: 0 selects edge-aligned, 1 selects centre-aligned; sampled at each period end.
- `i_sample`, in, CHANNELS*WIDTH: compare values; channel c occupies bits `[c*WIDTH +: WIDTH]`.
- `i_sample_valid`, in, 1: sample handshake valid.
- `o_sample_ready`, out, 1: high while the pending sample buffer is empty.
- `o_pwm`, out, CHANNELS: true outputs.
- `o_pwm_n`, out, CHANNELS: complementary outputs.
- `o_cycle_end`, out, 1: high during the last cycle of each period.
- `o_underrun`, out, 1: one-cycle pulse when a period ends with no pending sample.

## Operation

**Reset values**
- Counter = 0, direction up, active top = `RESET_TOP`, mode = edge.
- Active compares = 0, pending buffer empty.
- `o_sample_ready` = 1; `o_pwm`, `o_pwm_n`, `o_cycle_end` and `o_underrun` = 0.
- Asserting reset mid-period forces all of the above immediately. The first period after release starts at counter 0.

**Counter**
- Edge mode: 0, 1, …, top, then wraps to 0. Period = top+1 cycles.
- Centre mode: 0 up to top, then top−1 down to 1, then 0 again. Period = 2·top cycles.
- top = 0: counter holds 0 and `o_cycle_end` is high every cycle, in either mode.

**Period end** (clock edge closing a cycle with `o_cycle_end` = 1)
- Pending top, if loaded, becomes the active top.
- `i_mode` is latched.
- If the pending buffer is full, all pending compares move to active and the buffer empties.
- If the pending buffer is empty, the active compares are retained and `o_underrun` pulses in the next cycle.
- The counter restarts at 0 with direction up.

**Handshake**
- A transfer occurs on a cycle with `i_sample_valid` and `o_sample_ready` both high; this fills the buffer and drops `o_sample_ready`.
- `o_sample_ready` rises again in the cycle after the period-end transfer.
- There is no bypass: a sample accepted in the period-end cycle itself only goes to pending. It takes effect at the following period end.
- Multiple `i_top_valid` pulses within a period: the last one wins.

**Compare** (raw_c = counter < cmp_c, unsigned)
- cmp = 0: raw stays low.
- cmp > top: raw stays high for the whole period.
- Edge mode: high for cmp cycles.
- Centre mode: high for 2·cmp−1 cycles, symmetric about counter 0 (for 1 ≤ cmp ≤ top).

**Dead time**
- `o_pwm` rises DEAD_TIME cycles after the raw waveform rises; it falls with no extra delay.
- `o_pwm_n` is the same construction applied to the inverted raw waveform.
- A raw pulse of DEAD_TIME cycles or fewer never appears on the respective pin.
- `o_pwm[c]` and `o_pwm_n[c]` are never high together.

## Timing

- Raw compare result is registered: with DEAD_TIME = 0, `o_pwm` in cycle t+1 reflects the counter in cycle t.
- Dead time adds DEAD_TIME cycles to rising edges only.
- `o_cycle_end` is a decode of registered state, high in the same cycle the counter holds its last-period value.
- `o_sample_ready` falls one cycle after the accepting edge.
- All outputs are registered or decoded from registers; there is no combinational path from inputs to outputs.

## Test plan

- **Edge, basic:** CHANNELS=2, WIDTH=4, DEAD_TIME=0, top=7, sample {ch1=0, ch0=3} → ch0 high 3 of every 8 cycles, ch1 always low, `o_cycle_end` every 8th cycle, `o_pwm_n` = ~`o_pwm`.
- **Boundaries:** compare 8 with top=7 → `o_pwm` constantly 1; compare 0 → constantly 0. top=0 → `o_cycle_end` every cycle.
- **Centre mode:** mode=1, top=7, cmp=3 → period 14, `o_pwm` high 5 consecutive cycles centred on counter 0.
- **Dead time:** DEAD_TIME=2, edge, top=7, cmp=4 → `o_pwm` high 2 cycles, `o_pwm_n` high 2 cycles, 2 cycles both low after each transition, never both high. cmp=1 → `o_pwm` never high.
- **Handshake:** hold `i_sample_valid` high → exactly one accept per period, `o_sample_ready` low from accept until the cycle after period end. Sample offered in the period-end cycle → takes effect one period later. No sample supplied for a period → `o_underrun` pulses once and the previous duty is kept.
- **Async reset:** assert `i_rst_n` = 0 mid-period with the buffer full → all outputs 0 and `o_sample_ready` = 1 immediately. After release, the first period uses `RESET_TOP` and compares of 0.
